// File: rtl/s_machine_pkg.sv
// Shared definitions for the S-Machine load/store path: operand widths,
// request opcodes and the sequencer state encoding.
package s_machine_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    CAPTURE,
    RESP
  } state_e;

  function automatic logic is_write(input op_e op);
    return (op == OP_STORE) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/lsu_stack_ptr.sv
// Hardware stack pointer for the load/store unit: a downward-growing stack
// with full/empty flags and single-step commit.
module lsu_stack_ptr
  import s_machine_pkg::*;
#(
  parameter logic [ADDR_W-1:0] STACK_TOP   = 8'hFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_plus_one,
  output logic              full,
  output logic              empty
);

  // The sequencer never asks for both directions in one cycle; inc wins anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= STACK_TOP;
    end else if (inc) begin
      sp <= sp + 8'd1;
    end else if (dec) begin
      sp <= sp - 8'd1;
    end
  end

  assign sp_plus_one = sp + 8'd1;
  assign full        = (sp < STACK_LIMIT);
  assign empty       = (sp == STACK_TOP);

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a level-sensitive
// 256x16 data memory; owns the glitch-free memory drive and the stack pointer.
module load_store_unit
  import s_machine_pkg::*;
#(
  parameter logic [ADDR_W-1:0] STACK_TOP   = 8'hFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] sp_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state;
  op_e               op_q;
  op_e               op_in;
  logic              sp_inc;
  logic              sp_dec;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] sp_plus_one;
  logic              full;
  logic              empty;
  logic              req_err;
  logic [ADDR_W-1:0] eff_addr;

  lsu_stack_ptr #(
    .STACK_TOP  (STACK_TOP),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_stack_ptr (
    .clk        (clk),
    .rst        (rst),
    .inc        (sp_inc),
    .dec        (sp_dec),
    .sp         (sp),
    .sp_plus_one(sp_plus_one),
    .full       (full),
    .empty      (empty)
  );

  assign op_in   = op_e'(req_op);
  assign sp_out  = sp;
  assign req_err = ((op_in == OP_PUSH) && full) || ((op_in == OP_POP) && empty);

  always_comb begin
    eff_addr = req_addr;
    case (op_in)
      OP_PUSH: eff_addr = sp;
      OP_POP:  eff_addr = sp_plus_one;
      default: eff_addr = req_addr;
    endcase
  end

  // SP moves on the edge that enters RESP; faulted requests never reach these states.
  assign sp_inc = (state == CAPTURE) && (op_q == OP_POP);
  assign sp_dec = (state == HOLD) && (op_q == OP_PUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      op_q           <= OP_LOAD;
      mem_addr       <= '0;
      mem_read_write <= 1'b0;
      mem_data_in    <= '0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= op_in;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              // Address and data settle here, a full cycle before any write strobe.
              state    <= SETUP;
              mem_addr <= eff_addr;
              if (is_write(op_in)) begin
                mem_data_in <= req_wdata;
              end
            end
          end
        end
        SETUP: begin
          if (is_write(op_q)) begin
            state          <= WRITE;
            mem_read_write <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end
        WRITE: begin
          state          <= HOLD;
          mem_read_write <= 1'b0;
        end
        HOLD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        CAPTURE: begin
          state      <= RESP;
          resp_rdata <= mem_data_out;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          req_ready      <= 1'b1;
          mem_read_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed stack/memory cases plus
// randomized traffic compared against an array-based reference model.
module tb_load_store_unit;
  import s_machine_pkg::*;

  localparam logic [7:0] TOP   = 8'hFF;
  localparam logic [7:0] LIMIT = 8'hC0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  sp_out;
  logic [7:0]  mem_addr;
  logic        mem_read_write;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  int vec_count = 0;
  int err_count = 0;
  int rw_cycles = 0;

  logic [15:0] ref_mem [256];
  logic [7:0]  ref_sp;
  logic [15:0] ref_rdata;

  logic [15:0] mem [256];
  bit          written [256];
  logic [7:0]  prev_addr;
  logic [15:0] prev_data;

  always #5 clk = ~clk;

  load_store_unit #(
    .STACK_TOP  (TOP),
    .STACK_LIMIT(LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .sp_out        (sp_out),
    .mem_addr      (mem_addr),
    .mem_read_write(mem_read_write),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out)
  );

  function automatic logic [15:0] init_pattern(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A3C;
  endfunction

  // Level-sensitive memory: writes whenever read_write is high and anything moves.
  always @(mem_read_write or mem_addr or mem_data_in) begin
    if (mem_read_write) begin
      mem[mem_addr]     = mem_data_in;
      written[mem_addr] = 1'b1;
    end
  end

  assign mem_data_out = written[mem_addr] ? mem[mem_addr] : init_pattern(mem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Address and data must be identical to the cycle before whenever the strobe is high.
  always @(negedge clk) begin
    if (mem_read_write === 1'b1) begin
      rw_cycles++;
      checkOutput("addr_stable_in_write", 32'(mem_addr), 32'(prev_addr));
      checkOutput("data_stable_in_write", 32'(mem_data_in), 32'(prev_data));
    end
    prev_addr = mem_addr;
    prev_data = mem_data_in;
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr,
                               input logic [15:0] data, input bit hold);
    int         n;
    int         rw_start;
    bit         exp_err;
    bit         wr;
    bit         seen;
    int         exp_lat;
    logic [7:0] eff;
    logic [7:0] addr_before;

    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    checkOutput("resp_valid_idle", 32'(resp_valid), 0);

    wr      = (op == OP_STORE) || (op == OP_PUSH);
    exp_err = ((op == OP_PUSH) && (ref_sp < LIMIT)) || ((op == OP_POP) && (ref_sp == TOP));
    eff     = (op == OP_PUSH) ? ref_sp : (op == OP_POP) ? 8'(ref_sp + 8'd1) : addr;
    exp_lat = exp_err ? 1 : (wr ? 4 : 3);
    addr_before = mem_addr;
    rw_start    = rw_cycles;

    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);

    seen = 1'b0;
    for (n = 1; n <= 8; n++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      checkOutput("ready_low_busy", 32'(req_ready), 0);
      checkOutput("err_without_valid", 32'(resp_err), 0);
      @(negedge clk);
    end
    checkOutput("resp_seen", 32'(seen), 1);
    if (!seen) return;

    checkOutput("latency", n, exp_lat);
    checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
    checkOutput("rw_high_cycles", rw_cycles - rw_start, (wr && !exp_err) ? 1 : 0);
    checkOutput("mem_addr", 32'(mem_addr), exp_err ? 32'(addr_before) : 32'(eff));

    if (!exp_err) begin
      if (wr) begin
        ref_mem[eff] = data;
        checkOutput("mem_written", 32'(mem[eff]), 32'(data));
      end else begin
        ref_rdata = ref_mem[eff];
      end
      if (op == OP_PUSH) ref_sp = ref_sp - 8'd1;
      if (op == OP_POP)  ref_sp = ref_sp + 8'd1;
    end
    checkOutput("resp_rdata", 32'(resp_rdata), 32'(ref_rdata));
    checkOutput("sp", 32'(sp_out), 32'(ref_sp));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_pattern(8'(i));
    ref_sp    = TOP;
    ref_rdata = 16'h0000;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_ready", 32'(req_ready), 1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 0);
    checkOutput("reset_resp_err", 32'(resp_err), 0);
    checkOutput("reset_rdata", 32'(resp_rdata), 0);
    checkOutput("reset_sp", 32'(sp_out), 32'(TOP));
    checkOutput("reset_rw", 32'(mem_read_write), 0);
    checkOutput("reset_addr", 32'(mem_addr), 0);
    checkOutput("reset_data_in", 32'(mem_data_in), 0);

    applyStimulus(OP_POP, 8'h00, 16'h0000, 1'b0);
    applyStimulus(OP_STORE, 8'h10, 16'hBEEF, 1'b0);
    applyStimulus(OP_LOAD, 8'h10, 16'h0000, 1'b0);
    applyStimulus(OP_PUSH, 8'h00, 16'h1111, 1'b0);
    applyStimulus(OP_PUSH, 8'h00, 16'h2222, 1'b0);
    checkOutput("stack_ff", 32'(mem[8'hFF]), 32'h1111);
    checkOutput("stack_fe", 32'(mem[8'hFE]), 32'h2222);
    applyStimulus(OP_POP, 8'h00, 16'h0000, 1'b0);
    applyStimulus(OP_POP, 8'h00, 16'h0000, 1'b0);

    // Reset landing in the write strobe cycle of a store.
    applyStimulus(OP_PUSH, 8'h00, 16'h7777, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_STORE;
    req_addr  = 8'h33;
    req_wdata = 16'hCAFE;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    checkOutput("rst_test_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rw_in_write", 32'(mem_read_write), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_mem[8'h33] = 16'hCAFE;
    ref_sp    = TOP;
    ref_rdata = 16'h0000;
    checkOutput("rst_mid_rw", 32'(mem_read_write), 0);
    checkOutput("rst_mid_ready", 32'(req_ready), 1);
    checkOutput("rst_mid_sp", 32'(sp_out), 32'(TOP));
    checkOutput("rst_mid_rdata", 32'(resp_rdata), 0);
    repeat (6) begin
      checkOutput("no_resp_after_rst", 32'(resp_valid), 0);
      @(negedge clk);
    end
    checkOutput("store_before_rst", 32'(mem[8'h33]), 32'hCAFE);

    // Fill the stack until overflow, then drain it to underflow.
    for (int i = 0; i < 65; i++) applyStimulus(OP_PUSH, 8'h00, 16'(16'hA000 + i), 1'b0);
    checkOutput("full_sp", 32'(sp_out), 32'(8'(LIMIT - 8'd1)));
    for (int i = 0; i < 65; i++) applyStimulus(OP_POP, 8'h00, 16'h0000, 1'b0);
    checkOutput("drained_sp", 32'(sp_out), 32'(TOP));

    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'($urandom_range(3, 0)), 8'($urandom), 16'($urandom), bit'($urandom_range(1, 0)));
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Back-to-back demand with req_valid held high throughout.
    for (int i = 0; i < 10; i++) begin
      logic [7:0]  a;
      logic [15:0] d;
      a = 8'($urandom_range(8'hBF, 8'h00));
      d = 16'($urandom);
      applyStimulus(OP_STORE, a, d, 1'b1);
      applyStimulus(OP_LOAD, a, 16'h0000, 1'b1);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequencer between the S-Machine execute stage and the 256x16 data memory.
- Accepts one load, store, push or pop request per valid/ready handshake and maintains the hardware stack pointer.
- Drives the memory's level-sensitive address, read_write and data_in ports with glitch-free timing, then returns read data or a completion pulse.
- Memory writes occur whenever read_write is 1 and addr or read_write changes. The unit therefore only ever raises read_write with addr and data already stable, and never changes addr while read_write is 1.

Parameters:
- STACK_TOP, 8'hFF: reset value of SP; stack is empty when SP equals this; stack grows downward.
- STACK_LIMIT, 8'hC0: lowest address a push may write; stack is full when SP is below this.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP
- req_addr  in  8  absolute address for LOAD/STORE; ignored for PUSH/POP
- req_wdata  in  16  store/push data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  16  load/pop data; holds its last value otherwise
- resp_err  out  1  qualifies resp_valid: stack overflow or underflow
- sp_out  out  8  current stack pointer
- mem_addr  out  8  to data memory addr
- mem_read_write  out  1  to data memory read_write (1 = write)
- mem_data_in  out  16  to data memory data_in_memory
- mem_data_out  in  16  from data memory data_out_memory

Behaviour:
- Reset (clk edge with rst=1) forces:
  - state IDLE; SP=STACK_TOP
  - mem_read_write=0, mem_addr=0, mem_data_in=0
  - resp_valid=0, resp_err=0, resp_rdata=0
- rst has priority over every state. Asserting it mid-write drops mem_read_write to 0 at that edge, and the in-flight request is discarded with no response.
- All outputs are registered. req_ready = (state==IDLE). Accept = req_valid & req_ready at a rising edge; op, address and data are latched at that edge.
- FSM states: IDLE, SETUP, WRITE, HOLD, CAPTURE, RESP.
- Effective address:
  - LOAD/STORE: req_addr.
  - PUSH: SP.
  - POP: SP+1, 8-bit; no wrap occurs because underflow is checked first.
- Overflow: PUSH with SP < STACK_LIMIT. Underflow: POP with SP == STACK_TOP.
- Errors are detected at accept. The FSM goes IDLE->RESP with resp_err=1. There is no memory access, mem_read_write stays 0, and SP is unchanged.
- Read path (LOAD, POP):
  - IDLE->SETUP: mem_addr is driven, rw=0.
  - SETUP->CAPTURE.
  - In CAPTURE, resp_rdata<=mem_data_out at the exiting edge, then ->RESP.
  - resp_valid is high in the cycle after the 3rd edge counted from accept.
- Write path (STORE, PUSH):
  - SETUP: mem_addr and mem_data_in driven, rw=0.
  - WRITE: rw=1 for exactly one cycle.
  - HOLD: rw=0, addr held.
  - RESP: resp_valid is high after the 4th edge from accept.
- mem_addr and mem_data_in change only on entry to SETUP.
- SP update, committed on the edge entering RESP with no error: PUSH SP<=SP-1; POP SP<=SP+1.
- RESP lasts one cycle, then IDLE. A new request may be accepted in the following cycle. There are no back-to-back accepts, so throughput is at most 1 request per 4 or 5 cycles.
- resp_err is 0 whenever resp_valid is 0.
- req_valid may drop while the unit is busy without effect; the latched request completes.

Decomposition:
- Package s_machine_pkg holds:
  - op encodings: OP_LOAD, OP_STORE, OP_PUSH, OP_POP
  - the FSM state enum
  - ADDR_W=8, DATA_W=16
- One sub-module, lsu_stack_ptr: SP register, full/empty compare, inc/dec commit.
- The FSM and memory drive stay in load_store_unit.

Test Plan:
- Reset, then STORE addr 8'h10 data 16'hBEEF, then LOAD 8'h10 -> resp_rdata=16'hBEEF 3 cycles after accept; resp_err=0. mem_read_write is high exactly one cycle and mem_addr is stable across it.
- PUSH 16'h1111, PUSH 16'h2222 -> SP FF->FE->FD. Memory[FF]=1111 and [FE]=2222. POP returns 2222 with SP=FE; a second POP returns 1111 with SP=FF.
- POP at reset (SP=FF) -> resp_valid with resp_err=1 one edge after accept, mem_read_write never 1, SP stays FF.
- With STACK_LIMIT=8'hFE: push FF and FE succeed, a third push sees SP=FD and returns resp_err=1. Memory[FD] is unchanged and SP stays FD.
- Assert rst during WRITE of a store -> next cycle mem_read_write=0, req_ready=1, resp_valid never pulses, SP=FF.
- Hold req_valid high with alternating STORE/LOAD ops -> req_ready low throughout each transaction, and every accept is followed by exactly one resp_valid pulse in order.
